// File: rtl/gol_ctrl.sv
// Run controller for a toroidal Game of Life array: load, step, free/bounded runs, stability/extinction flags.
// Optional build macro GOL_AUTO_HALT_EN: a rising stable/extinct flag in RUN ends the run in DONE.
module gol_ctrl #(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10,
    parameter int CNT_W  = 16,
    parameter int DIV_W  = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_load,
    input  logic                    cmd_run,
    input  logic                    cmd_stop,
    input  logic                    cmd_step,
    input  logic [CNT_W-1:0]        gen_limit,
    input  logic [DIV_W-1:0]        period,
    input  logic [WIDTH*HEIGHT-1:0] cells,
    output logic                    grid_load_n,
    output logic                    grid_adv,
    output logic [CNT_W-1:0]        gen_count,
    output logic [1:0]              state,
    output logic                    stable,
    output logic                    extinct
);

    localparam int N = WIDTH * HEIGHT;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] timer_q, timer_d;
    logic [DIV_W-1:0] per_q, per_d;
    logic [DIV_W-1:0] eff_period;
    logic [CNT_W-1:0] gen_q, gen_d, gen_inc;
    logic             step_q, step_d;
    logic             cmp_q, cmp_d;
    logic             stable_q, stable_d;
    logic             extinct_q, extinct_d;
    logic [N-1:0]     prev_q, prev_d;
    logic             wrap, halt, adv;

    assign eff_period = (period < DIV_W'(2)) ? DIV_W'(2) : period;
    assign gen_inc    = (gen_q == '1) ? gen_q : gen_q + CNT_W'(1);
    // per_q latches the period only at run start and at each wrap, so edits apply from the next generation.
    assign wrap       = (state_q == ST_RUN) && (timer_q >= per_q - DIV_W'(1));

`ifdef GOL_AUTO_HALT_EN
    logic stable_dly_q, extinct_dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stable_dly_q  <= 1'b0;
            extinct_dly_q <= 1'b0;
        end else begin
            stable_dly_q  <= stable_q;
            extinct_dly_q <= extinct_q;
        end
    end

    assign halt = (stable_q & ~stable_dly_q) | (extinct_q & ~extinct_dly_q);
`else
    assign halt = 1'b0;
`endif

    // Reset gates the strobe so a reset edge never doubles as an advance edge.
    assign adv = ~rst & ((wrap & ~halt) | step_q);

    // NOTE: every variable gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        per_d     = per_q;
        gen_d     = gen_q;
        step_d    = 1'b0;
        cmp_d     = cmp_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        extinct_d = (cells == '0);

        if (cmp_q) begin
            stable_d = (cells == prev_q);
            cmp_d    = 1'b0;
        end
        if (adv) begin
            gen_d  = gen_inc;
            prev_d = cells;
            cmp_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_load) begin
                    state_d = ST_LOAD;
                end else if (cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (cmd_run) begin
                    state_d = ST_RUN;
                    gen_d   = '0;
                    timer_d = '0;
                    per_d   = eff_period;
                end else if (cmd_step) begin
                    step_d = 1'b1;
                end
            end
            ST_LOAD: begin
                gen_d    = '0;
                stable_d = 1'b0;
                cmp_d    = 1'b0;
                state_d  = cmd_load ? ST_LOAD : ST_IDLE;
            end
            ST_RUN: begin
                if (wrap) begin
                    timer_d = '0;
                    per_d   = eff_period;
                end else begin
                    timer_d = timer_q + DIV_W'(1);
                end
                if (cmd_load) begin
                    state_d = ST_LOAD;
                end else if (cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (halt) begin
                    state_d = ST_DONE;
                end else if (wrap && (gen_limit != '0) && (gen_inc >= gen_limit)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (cmd_load) begin
                    state_d = ST_LOAD;
                end else if (cmd_stop) begin
                    state_d = ST_IDLE;
                end else if (cmd_run) begin
                    state_d = ST_RUN;
                    gen_d   = '0;
                    timer_d = '0;
                    per_d   = eff_period;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            per_q     <= DIV_W'(2);
            gen_q     <= '0;
            step_q    <= 1'b0;
            cmp_q     <= 1'b0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            per_q     <= per_d;
            gen_q     <= gen_d;
            step_q    <= step_d;
            cmp_q     <= cmp_d;
            stable_q  <= stable_d;
            extinct_q <= extinct_d;
        end
    end

    // NOTE: the snapshot is not reset; it is only read while cmp_q is set, which reset clears.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
    end

    assign grid_load_n = (state_q != ST_LOAD);
    assign grid_adv    = adv;
    assign gen_count   = gen_q;
    assign state       = state_q;
    assign stable      = stable_q;
    assign extinct     = extinct_q;

endmodule

// File: tb/tb_gol_ctrl.sv
// Bench for gol_ctrl: a behavioural cell array closes the loop; expected advances are queued and
// popped by a monitor, scenario tasks check state and flags inline.
module tb_gol_ctrl;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int N  = W * H;
    localparam int CW = 16;
    localparam int DW = 24;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, cmd_load, cmd_run, cmd_stop, cmd_step;
    logic [CW-1:0] gen_limit;
    logic [DW-1:0] period;
    logic [N-1:0]  cells = '0;
    logic [N-1:0]  init_pat = '0;
    logic          grid_load_n, grid_adv, stable, extinct;
    logic [CW-1:0] gen_count;
    logic [1:0]    state;

    logic          s_rst, s_step;
    logic [N-1:0]  s_cells;
    logic          s_load_n, s_adv, s_stable, s_extinct;
    logic [3:0]    s_gen;
    logic [1:0]    s_state;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int cyc;
        int gen;
    } adv_exp_t;
    adv_exp_t adv_q[$];

    gol_ctrl #(.WIDTH(W), .HEIGHT(H), .CNT_W(CW), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .cmd_load(cmd_load), .cmd_run(cmd_run), .cmd_stop(cmd_stop),
        .cmd_step(cmd_step), .gen_limit(gen_limit), .period(period), .cells(cells),
        .grid_load_n(grid_load_n), .grid_adv(grid_adv), .gen_count(gen_count),
        .state(state), .stable(stable), .extinct(extinct)
    );

    gol_ctrl #(.WIDTH(W), .HEIGHT(H), .CNT_W(4), .DIV_W(DW)) dut_sat (
        .clk(clk), .rst(s_rst), .cmd_load(1'b0), .cmd_run(1'b0), .cmd_stop(1'b0),
        .cmd_step(s_step), .gen_limit(4'd0), .period(24'd2), .cells(s_cells),
        .grid_load_n(s_load_n), .grid_adv(s_adv), .gen_count(s_gen),
        .state(s_state), .stable(s_stable), .extinct(s_extinct)
    );

    function automatic int idx(input int r, input int c);
        return r * W + c;
    endfunction

    function automatic logic [N-1:0] next_gen(input logic [N-1:0] g);
        logic [N-1:0] n;
        int cnt;
        n = '0;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                cnt = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            cnt += int'(g[idx((r + dr + H) % H, (c + dc + W) % W)]);
                n[idx(r, c)] = (cnt == 3) || (g[idx(r, c)] && cnt == 2);
            end
        end
        return n;
    endfunction

    // Behavioural cell array driven by the controller's strobes.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (grid_load_n === 1'b0)
            cells <= init_pat;
        else if (grid_adv === 1'b1)
            cells <= next_gen(cells);
    end

    // Scoreboard consumer: every advance must match the next queued cycle and pre-advance count.
    always @(negedge clk) begin
        if (grid_adv === 1'b1) begin
            adv_exp_t e;
            checks++;
            if (adv_q.size() == 0) begin
                errors++;
                $display("FAIL adv_unexpected: grid_adv at cycle %0d, none expected", cyc);
            end else begin
                e = adv_q.pop_front();
                if (e.cyc != cyc || gen_count !== CW'(e.gen)) begin
                    errors++;
                    $display("FAIL adv_sched: got cycle %0d gen %0d, want cycle %0d gen %0d",
                             cyc, gen_count, e.cyc, e.gen);
                end
            end
            if (grid_load_n !== 1'b1) begin
                errors++;
                $display("FAIL adv_and_load: grid_load_n=%0b during grid_adv", grid_load_n);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic pulse(input logic l, input logic r, input logic s, input logic st);
        cmd_load = l; cmd_run = r; cmd_stop = s; cmd_step = st;
        @(negedge clk);
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0;
    endtask

    task automatic do_load(input logic [N-1:0] pat);
        init_pat = pat;
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd1 || grid_load_n !== 1'b0 || grid_adv !== 1'b0) begin
            errors++;
            $display("FAIL load_strobe: state=%0d load_n=%0b adv=%0b, want 1/0/0", state, grid_load_n, grid_adv);
        end
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || grid_load_n !== 1'b1 || gen_count !== '0 || stable !== 1'b0) begin
            errors++;
            $display("FAIL load_exit: state=%0d load_n=%0b gen=%0d stable=%0b, want 0/1/0/0",
                     state, grid_load_n, gen_count, stable);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; s_rst = 1'b1;
        cmd_load = 1'b0; cmd_run = 1'b0; cmd_stop = 1'b0; cmd_step = 1'b0; s_step = 1'b0;
        gen_limit = '0; period = DW'(5); s_cells = '0; s_cells[idx(3, 3)] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0; s_rst = 1'b0;
        checks++;
        if (state !== 2'd0 || grid_load_n !== 1'b1 || grid_adv !== 1'b0 || gen_count !== '0 ||
            stable !== 1'b0 || extinct !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d load_n=%0b adv=%0b gen=%0d stable=%0b extinct=%0b, want 0/1/0/0/0/0",
                     state, grid_load_n, grid_adv, gen_count, stable, extinct);
        end
    endtask

    task automatic test_step_block();
        logic [N-1:0] pat;
        int a;
        pat = '0;
        pat[idx(4, 4)] = 1'b1; pat[idx(4, 5)] = 1'b1; pat[idx(5, 4)] = 1'b1; pat[idx(5, 5)] = 1'b1;
        do_load(pat);
        a = cyc + 1;
        adv_q.push_back('{cyc: a, gen: 0});
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (gen_count !== CW'(1) || grid_adv !== 1'b0 || stable !== 1'b0 || state !== 2'd0) begin
            errors++;
            $display("FAIL step_count: gen=%0d adv=%0b stable=%0b state=%0d, want 1/0/0/0",
                     gen_count, grid_adv, stable, state);
        end
        @(negedge clk);
        checks++;
        if (stable !== 1'b1 || extinct !== 1'b0 || cells !== pat) begin
            errors++;
            $display("FAIL step_stable: stable=%0b extinct=%0b cells_ok=%0b, want 1/0/1",
                     stable, extinct, cells === pat);
        end
        checks++;
        if (adv_q.size() != 0) begin
            errors++;
            $display("FAIL step_missing: %0d advances outstanding, want 0", adv_q.size());
            adv_q.delete();
        end
    endtask

    task automatic test_extinct_run();
        logic [N-1:0] pat;
        int t;
        int want_gen;
        pat = '0;
        pat[idx(2, 3)] = 1'b1;
        do_load(pat);
        period = DW'(5); gen_limit = '0;
        t = cyc;
`ifdef GOL_AUTO_HALT_EN
        adv_q.push_back('{cyc: t + 5, gen: 0});
        want_gen = 1;
`else
        for (int k = 1; k <= 4; k++) adv_q.push_back('{cyc: t + 5 * k, gen: k - 1});
        want_gen = 4;
`endif
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL run_enter: state=%0d, want 2", state);
        end
        wait_until(t + 6);
        checks++;
        if (extinct !== 1'b0) begin
            errors++;
            $display("FAIL extinct_early: extinct=%0b, want 0", extinct);
        end
        @(negedge clk);
        checks++;
        if (extinct !== 1'b1) begin
            errors++;
            $display("FAIL extinct_flag: extinct=%0b, want 1", extinct);
        end
`ifdef GOL_AUTO_HALT_EN
        @(negedge clk);
        checks++;
        if (state !== 2'd3 || gen_count !== CW'(1)) begin
            errors++;
            $display("FAIL auto_halt: state=%0d gen=%0d, want 3/1", state, gen_count);
        end
`endif
        wait_until(t + 21);
        checks++;
`ifdef GOL_AUTO_HALT_EN
        if (state !== 2'd3 || gen_count !== CW'(want_gen)) begin
`else
        if (state !== 2'd2 || gen_count !== CW'(want_gen)) begin
`endif
            errors++;
            $display("FAIL extinct_run_state: state=%0d gen=%0d, want gen %0d", state, gen_count, want_gen);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (state !== 2'd0 || gen_count !== CW'(want_gen) || adv_q.size() != 0) begin
            errors++;
            $display("FAIL extinct_stop: state=%0d gen=%0d pending=%0d, want 0/%0d/0",
                     state, gen_count, adv_q.size(), want_gen);
            adv_q.delete();
        end
    endtask

    function automatic logic [N-1:0] blinker();
        logic [N-1:0] p;
        p = '0;
        p[idx(4, 3)] = 1'b1; p[idx(4, 4)] = 1'b1; p[idx(4, 5)] = 1'b1;
        return p;
    endfunction

    task automatic test_blinker_limit();
        int t;
        do_load(blinker());
        period = DW'(2); gen_limit = CW'(6);
        t = cyc;
        for (int k = 1; k <= 6; k++) adv_q.push_back('{cyc: t + 2 * k, gen: k - 1});
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_until(t + 13);
        checks++;
        if (state !== 2'd3 || gen_count !== CW'(6) || grid_adv !== 1'b0 || stable !== 1'b0) begin
            errors++;
            $display("FAIL limit_done: state=%0d gen=%0d adv=%0b stable=%0b, want 3/6/0/0",
                     state, gen_count, grid_adv, stable);
        end
        wait_until(t + 20);
        checks++;
        if (state !== 2'd3 || stable !== 1'b0 || cells !== blinker() || adv_q.size() != 0) begin
            errors++;
            $display("FAIL limit_hold: state=%0d stable=%0b cells_ok=%0b pending=%0d, want 3/0/1/0",
                     state, stable, cells === blinker(), adv_q.size());
            adv_q.delete();
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_glider();
        logic [N-1:0] pat;
        int t;
        pat = '0;
        pat[idx(1, 2)] = 1'b1; pat[idx(2, 3)] = 1'b1;
        pat[idx(3, 1)] = 1'b1; pat[idx(3, 2)] = 1'b1; pat[idx(3, 3)] = 1'b1;
        do_load(pat);
        period = DW'(2); gen_limit = '0;
        t = cyc;
        for (int k = 1; k <= 40; k++) adv_q.push_back('{cyc: t + 2 * k, gen: k - 1});
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_until(t + 81);
        checks++;
        if (state !== 2'd2 || gen_count !== CW'(40)) begin
            errors++;
            $display("FAIL glider_run: state=%0d gen=%0d, want 2/40", state, gen_count);
        end
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (state !== 2'd0 || gen_count !== CW'(40) || cells !== pat || adv_q.size() != 0) begin
            errors++;
            $display("FAIL glider_stop: state=%0d gen=%0d cells_ok=%0b pending=%0d, want 0/40/1/0",
                     state, gen_count, cells === pat, adv_q.size());
            adv_q.delete();
        end
    endtask

    task automatic test_load_priority();
        int t;
        do_load(blinker());
        period = DW'(5); gen_limit = '0;
        t = cyc;
        adv_q.push_back('{cyc: t + 5, gen: 0});
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_until(t + 7);
        cmd_load = 1'b1; cmd_run = 1'b1;
        @(negedge clk);
        cmd_load = 1'b0; cmd_run = 1'b0;
        checks++;
        if (state !== 2'd1 || grid_load_n !== 1'b0 || grid_adv !== 1'b0) begin
            errors++;
            $display("FAIL prio_load: state=%0d load_n=%0b adv=%0b, want 1/0/0", state, grid_load_n, grid_adv);
        end
        @(negedge clk);
        checks++;
        if (state !== 2'd0 || grid_load_n !== 1'b1 || gen_count !== '0 || cells !== blinker() ||
            adv_q.size() != 0) begin
            errors++;
            $display("FAIL prio_idle: state=%0d load_n=%0b gen=%0d pending=%0d, want 0/1/0/0",
                     state, grid_load_n, gen_count, adv_q.size());
            adv_q.delete();
        end
    endtask

    task automatic test_reset_mid_run();
        logic [N-1:0] pat;
        int t;
        pat = '0;
        pat[idx(0, 0)] = 1'b1; pat[idx(0, 9)] = 1'b1; pat[idx(9, 0)] = 1'b1; pat[idx(9, 9)] = 1'b1;
        do_load(pat);
        period = DW'(5); gen_limit = '0;
        t = cyc;
        adv_q.push_back('{cyc: t + 5, gen: 0});
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        wait_until(t + 7);
        checks++;
        if (stable !== 1'b1 || gen_count !== CW'(1)) begin
            errors++;
            $display("FAIL wrap_block_stable: stable=%0b gen=%0d, want 1/1", stable, gen_count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (state !== 2'd0 || grid_load_n !== 1'b1 || grid_adv !== 1'b0 || gen_count !== '0 ||
            stable !== 1'b0 || extinct !== 1'b0 || cells !== pat) begin
            errors++;
            $display("FAIL rst_mid_run: state=%0d load_n=%0b adv=%0b gen=%0d stable=%0b extinct=%0b cells_ok=%0b",
                     state, grid_load_n, grid_adv, gen_count, stable, extinct, cells === pat);
        end
        wait_until(t + 20);
        checks++;
        if (state !== 2'd0 || gen_count !== '0 || adv_q.size() != 0) begin
            errors++;
            $display("FAIL rst_quiet: state=%0d gen=%0d pending=%0d, want 0/0/0", state, gen_count, adv_q.size());
            adv_q.delete();
        end
    endtask

    task automatic test_min_period();
        int t;
        for (int p = 0; p < 2; p++) begin
            do_load(blinker());
            period = DW'(p); gen_limit = CW'(3);
            t = cyc;
            for (int k = 1; k <= 3; k++) adv_q.push_back('{cyc: t + 2 * k, gen: k - 1});
            pulse(1'b0, 1'b1, 1'b0, 1'b0);
            wait_until(t + 7);
            checks++;
            if (state !== 2'd3 || gen_count !== CW'(3) || adv_q.size() != 0) begin
                errors++;
                $display("FAIL min_period_%0d: state=%0d gen=%0d pending=%0d, want 3/3/0",
                         p, state, gen_count, adv_q.size());
                adv_q.delete();
            end
            pulse(1'b0, 1'b0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_saturation();
        int want;
        for (int k = 1; k <= 20; k++) begin
            s_step = 1'b1;
            @(negedge clk);
            s_step = 1'b0;
            @(negedge clk);
            want = (k > 15) ? 15 : k;
            checks++;
            if (s_gen !== 4'(want)) begin
                errors++;
                $display("FAIL sat_step_%0d: gen=%0d, want %0d", k, s_gen, want);
            end
        end
        checks++;
        if (s_state !== 2'd0 || s_load_n !== 1'b1 || s_adv !== 1'b0 || s_stable !== 1'b1 ||
            s_extinct !== 1'b0) begin
            errors++;
            $display("FAIL sat_flags: state=%0d load_n=%0b adv=%0b stable=%0b extinct=%0b, want 0/1/0/1/0",
                     s_state, s_load_n, s_adv, s_stable, s_extinct);
        end
    endtask

    initial begin
        test_reset();
        test_step_block();
        test_extinct_run();
        test_blinker_limit();
        test_glider();
        test_load_priority();
        test_reset_mid_run();
        test_min_period();
        test_saturation();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gol_ctrl.md
Name: gol_ctrl

Overview:
Run controller for the toroidal Game of Life cell array. It sequences pattern load, free-running, single-step and bounded runs. It drives the array's active-low load strobe and a per-generation advance enable. It observes the full cell vector to count generations and flag still-life and extinction, and sits between the user/host command interface and the cell array.

Parameters:
WIDTH, 10, grid columns
HEIGHT, 10, grid rows
CNT_W, 16, generation counter / limit width
DIV_W, 24, generation period timer width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cmd_load  in  1  one-cycle pulse: reload grid from its init pattern
cmd_run  in  1  one-cycle pulse: start free/bounded run
cmd_stop  in  1  one-cycle pulse: stop run, return to IDLE
cmd_step  in  1  one-cycle pulse: advance exactly one generation (IDLE only)
gen_limit  in  CNT_W  generations per run; 0 = unlimited
period  in  DIV_W  clk cycles per generation in RUN; values <2 treated as 2
cells  in  WIDTH*HEIGHT  current grid state from array
grid_load_n  out  1  active-low load strobe to array
grid_adv  out  1  one-cycle pulse: array advances one generation at this edge
gen_count  out  CNT_W  generations since last load/run start, saturating
state  out  2  IDLE=0, LOAD=1, RUN=2, DONE=3
stable  out  1  last advance produced identical grid
extinct  out  1  grid all-zero

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, grid_load_n=1, grid_adv=0, gen_count=0, stable=0, extinct=0, timer=0. The array is not reloaded by rst.
- Command priority in the same cycle: rst > cmd_load > cmd_stop > cmd_run > cmd_step.
- cmd_load (any state) -> LOAD for exactly 1 cycle. grid_load_n=0 during that cycle, gen_count<=0, stable<=0, then IDLE. Any pending compare is discarded.
- IDLE:
  - cmd_run -> RUN, gen_count<=0, timer<=0.
  - cmd_step -> grid_adv=1 on the next cycle, gen_count+1; remains IDLE.
  - cmd_stop has no effect.
- RUN:
  - Timer counts 0..eff_period-1, where eff_period = max(period, 2).
  - grid_adv=1 in the cycle the timer equals eff_period-1; timer then wraps to 0 and gen_count increments on the same edge.
  - Changes to period take effect at the next wrap.
  - cmd_stop -> IDLE; gen_count is held.
  - If gen_limit≠0 and gen_count reaches gen_limit on an advance edge -> DONE. The DONE transition occurs on that same edge.
  - cmd_step is ignored.
- DONE: holds, grid_adv=0. cmd_run -> RUN with gen_count<=0. cmd_load -> LOAD. cmd_stop -> IDLE.
- Stability compare:
  - On every grid_adv cycle, snapshot prev<=cells.
  - In the following cycle (cells now the new generation), stable<=(cells==prev), visible the cycle after that.
  - stable is otherwise held; it is cleared by load and rst.
  - Period ≥2 guarantees the compare finishes before the next advance.
- extinct <= (cells==0), registered every cycle (1-cycle lag), in all states except reset.
- gen_count saturates at 2^CNT_W-1 and does not wrap.
- grid_adv and grid_load_n are never both active.
- grid_adv is never issued in LOAD or DONE.

Optional Feature:
GOL_AUTO_HALT_EN:
- Defined: in RUN, a rising stable or extinct flag forces RUN->DONE on the next edge. Any grid_adv already scheduled for that edge is suppressed.
- Undefined: flags are reported only; the run continues until gen_limit or cmd_stop.

Test Plan:
1. Load 2x2 block at (4,4)-(5,5), cmd_step -> exactly one grid_adv pulse, gen_count=1; stable=1 two cycles after grid_adv; extinct=0.
2. Load single live cell, period=5, gen_limit=0, cmd_run -> grid_adv at cycles 5,10,...; extinct=1 one cycle after first advance. With GOL_AUTO_HALT_EN: state=DONE after gen_count=1. Without: still RUN at gen_count=4.
3. Load horizontal blinker, period=2, gen_limit=6, cmd_run -> 6 grid_adv pulses 2 cycles apart, state=DONE, gen_count=6, stable stays 0.
4. Glider, gen_limit=0, run 40 gens on 10x10 -> pattern identical to load state shifted (wraps torus); cmd_stop -> IDLE, gen_count=40 held.
5. Same-cycle cmd_load+cmd_run in RUN -> LOAD wins, grid_load_n low 1 cycle, then IDLE, gen_count=0. rst asserted mid-RUN -> next cycle IDLE, all outputs at reset values, grid_adv never pulses.
6. period=0 and period=1 -> advances every 2 cycles; gen_count preset near max (CNT_W=4, 20 steps) -> saturates at 15.
